// File: rtl/mips_pkg.sv
// Shared register-number type and forwarding-select encodings for the MIPS hazard logic.
// Pure declarations; no latency or flow control.
package mips_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_num_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam reg_num_t REG_ZERO = 5'd0;
endpackage

// File: rtl/dest_reg_hazard_unit_src_match.sv
// One source-vs-destination comparator with write qualification and $0 exclusion.
// Purely combinational; no backpressure.
module src_match
  import mips_pkg::*;
#(
  parameter int W = mips_pkg::REG_W
) (
  input  logic [W-1:0] src,
  input  logic         use_src,
  input  logic [W-1:0] dest,
  input  logic         wr,
  output logic         hit
);
  assign hit = use_src & wr & (dest != W'(REG_ZERO)) & (src == dest);
endmodule

// File: rtl/dest_reg_hazard_unit.sv
// Load-use stall, EX forwarding selects and decode write-bypass from shadowed EX/MEM/WB destinations.
// Outputs are combinational from registered shadow state plus decode/EX inputs; stall is the only backpressure.
module dest_reg_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_W       = mips_pkg::REG_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [REG_W-1:0]       ex_dest,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  output logic                   stall,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   id_byp_rs,
  output logic                   id_byp_rt,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic [REG_W-1:0] ex_rs_q, ex_rt_q, mem_dest_q, wb_dest_q;
  logic             ex_use_rs_q, ex_use_rt_q, ex_valid_q;
  logic             mem_wr_q, wb_wr_q;

  logic ex_wr_eff;
  logic ld_hit_rs, ld_hit_rt;
  logic a_mem_hit, a_wb_hit, b_mem_hit, b_wb_hit;

  // A bubble in EX must never look like a writer, whatever the external control says.
  assign ex_wr_eff = ex_reg_write & ex_valid_q;

  src_match #(.W(REG_W)) u_id_ex_rs (.src(id_rs), .use_src(id_use_rs), .dest(ex_dest),
                                     .wr(ex_wr_eff), .hit(ld_hit_rs));
  src_match #(.W(REG_W)) u_id_ex_rt (.src(id_rt), .use_src(id_use_rt), .dest(ex_dest),
                                     .wr(ex_wr_eff), .hit(ld_hit_rt));
  src_match #(.W(REG_W)) u_ex_mem_a (.src(ex_rs_q), .use_src(ex_use_rs_q), .dest(mem_dest_q),
                                     .wr(mem_wr_q), .hit(a_mem_hit));
  src_match #(.W(REG_W)) u_ex_wb_a  (.src(ex_rs_q), .use_src(ex_use_rs_q), .dest(wb_dest_q),
                                     .wr(wb_wr_q), .hit(a_wb_hit));
  src_match #(.W(REG_W)) u_ex_mem_b (.src(ex_rt_q), .use_src(ex_use_rt_q), .dest(mem_dest_q),
                                     .wr(mem_wr_q), .hit(b_mem_hit));
  src_match #(.W(REG_W)) u_ex_wb_b  (.src(ex_rt_q), .use_src(ex_use_rt_q), .dest(wb_dest_q),
                                     .wr(wb_wr_q), .hit(b_wb_hit));
  src_match #(.W(REG_W)) u_id_wb_rs (.src(id_rs), .use_src(id_use_rs), .dest(wb_dest_q),
                                     .wr(wb_wr_q), .hit(id_byp_rs));
  src_match #(.W(REG_W)) u_id_wb_rt (.src(id_rt), .use_src(id_use_rt), .dest(wb_dest_q),
                                     .wr(wb_wr_q), .hit(id_byp_rt));

  assign stall = ex_mem_read & (ld_hit_rs | ld_hit_rt);

  // MEM holds the youngest value, so it wins over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (a_mem_hit)     fwd_a = FWD_MEM;
    else if (a_wb_hit) fwd_a = FWD_WB;
    if (b_mem_hit)     fwd_b = FWD_MEM;
    else if (b_wb_hit) fwd_b = FWD_WB;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_dest_q  <= '0;
      mem_wr_q    <= 1'b0;
      wb_dest_q   <= '0;
      wb_wr_q     <= 1'b0;
      stall_count <= '0;
    end else begin
      mem_dest_q <= ex_dest;
      mem_wr_q   <= ex_wr_eff;
      wb_dest_q  <= mem_dest_q;
      wb_wr_q    <= mem_wr_q;
      ex_rs_q    <= id_rs;
      ex_rt_q    <= id_rt;
      if (stall) begin
        ex_use_rs_q <= 1'b0;
        ex_use_rt_q <= 1'b0;
        ex_valid_q  <= 1'b0;
        if (stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
      end else begin
        ex_use_rs_q <= id_use_rs;
        ex_use_rt_q <= id_use_rt;
        ex_valid_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dest_reg_hazard_unit.sv
// Directed checks of stall/forward/bypass behaviour; a second narrow-counter instance exercises saturation.
module tb_dest_reg_hazard_unit;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_use_rs, id_use_rt, ex_reg_write, ex_mem_read;
  logic       stall, id_byp_rs, id_byp_rt;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic       s_stall, s_byp_rs, s_byp_rt;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [3:0] s_count;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  dest_reg_hazard_unit dut (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_rs(id_byp_rs), .id_byp_rt(id_byp_rt),
    .stall_count(stall_count)
  );

  dest_reg_hazard_unit #(.STALL_CNT_W(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .stall(s_stall),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .id_byp_rs(s_byp_rs), .id_byp_rt(s_byp_rt),
    .stall_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_dest = dst; ex_reg_write = rw; ex_mem_read = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(5'd3, 5'd4, 1, 1, 5'd3, 1, 1);
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_fwd_b", fwd_b, 2'b00);
    chk("rst_byp_rs", id_byp_rs, 0);
    chk("rst_byp_rt", id_byp_rt, 0);
    chk("rst_count", stall_count, 0);

    // Release: EX slot empty, so the load in EX cannot stall yet.
    reset_n = 1'b1;
    #1;
    chk("post_rst_no_stall", stall, 0);
    tick();
    chk("ex_slot_loaded_stall", stall, 1);
    chk("ex_slot_loaded_fwd_a", fwd_a, 2'b00);

    // ALU back-to-back on $8.
    drive(5'd8, 5'd0, 1, 0, 5'd8, 1, 0);
    chk("alu_no_stall", stall, 0);
    tick();
    chk("alu_fwd_mem", fwd_a, 2'b10);
    drive(5'd8, 5'd0, 1, 0, 5'd0, 0, 0);
    tick();
    chk("alu_fwd_wb", fwd_a, 2'b01);
    chk("alu_fwd_b_rf", fwd_b, 2'b00);
    chk("alu_id_byp_rs", id_byp_rs, 1);

    // Load-use on $9 via rt.
    drive(5'd0, 5'd9, 0, 1, 5'd9, 1, 1);
    chk("lu_stall", stall, 1);
    chk("lu_count_before", stall_count, 0);
    tick();
    chk("lu_bubble_no_stall", stall, 0);
    chk("lu_count_after", stall_count, 1);
    tick();
    chk("lu_fwd_b_wb", fwd_b, 2'b01);
    drive(5'd0, 5'd0, 0, 0, 5'd10, 1, 0);
    chk("lu_no_second_stall", stall, 0);
    tick();
    chk("lu_count_hold", stall_count, 1);

    // MEM and WB both write $5: MEM wins, then WB alone.
    drive(5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
    tick();
    drive(5'd5, 5'd0, 1, 0, 5'd5, 1, 0);
    tick();
    chk("prio_fwd_mem", fwd_a, 2'b10);
    chk("prio_id_byp", id_byp_rs, 1);
    drive(5'd5, 5'd0, 1, 0, 5'd6, 1, 0);
    tick();
    chk("prio_wb_only", fwd_a, 2'b01);

    // Register 0 is never a hazard.
    drive(5'd0, 5'd0, 1, 1, 5'd0, 1, 1);
    chk("zero_no_stall", stall, 0);
    tick();
    chk("zero_fwd_a_mem", fwd_a, 2'b00);
    chk("zero_fwd_b_mem", fwd_b, 2'b00);
    tick();
    chk("zero_fwd_a_wb", fwd_a, 2'b00);
    chk("zero_byp_rs", id_byp_rs, 0);
    chk("zero_byp_rt", id_byp_rt, 0);
    chk("zero_stall_2", stall, 0);
    chk("zero_count", stall_count, 1);

    // Repeated load-use: alternates stall/bubble, 19 stalls over 38 edges.
    drive(5'd0, 5'd9, 0, 1, 5'd9, 1, 1);
    for (int i = 0; i < 38; i++) tick();
    chk("sat_main_count", stall_count, 20);
    chk("sat_narrow_count", s_count, 4'hF);

    // Put a live writer in MEM, then drop reset between edges.
    drive(5'd9, 5'd0, 1, 0, 5'd9, 1, 0);
    tick();
    drive(5'd9, 5'd0, 1, 0, 5'd9, 1, 1);
    chk("pre_arst_fwd_a", fwd_a, 2'b10);
    chk("pre_arst_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_fwd_a", fwd_a, 2'b00);
    chk("arst_stall", stall, 0);
    chk("arst_count", stall_count, 0);
    chk("arst_narrow_count", s_count, 0);

    reset_n = 1'b1;
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    tick();
    chk("post_arst_fwd_b", fwd_b, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dest_reg_hazard_unit.md
Name: dest_reg_hazard_unit

Overview:
- Consumer side of the destination-register select. Takes the 5-bit write-register number chosen in EX (rt vs rd), plus its write/load flags.
- Pipes that destination through its own MEM and WB shadow stages, and holds the EX-stage source registers.
- Compares these against decode-stage and EX-stage sources. Produces the load-use stall, the EX operand forwarding selects, and the decode-stage write-bypass flags.
- Sits beside the ID/EX/MEM/WB pipeline registers in the pipelined MIPS datapath.

Parameters:
- REG_W, 5, register-number width (32 GPRs).
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  decode-stage rs number.
- id_rt  in  REG_W  decode-stage rt number.
- id_use_rs  in  1  decode instruction reads rs.
- id_use_rt  in  1  decode instruction reads rt.
- ex_dest  in  REG_W  EX-stage destination (output of the rt/rd select).
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- stall  out  1  freeze PC/IF-ID and insert a bubble into ID/EX.
- fwd_a  out  2  EX operand A source: 00 = regfile, 10 = MEM result, 01 = WB result.
- fwd_b  out  2  EX operand B source, same encoding.
- id_byp_rs  out  1  WB is writing id_rs this cycle; decode uses the WB data.
- id_byp_rt  out  1  same, for id_rt.
- stall_count  out  STALL_CNT_W  number of load-use stall cycles, saturating.

Interface decision (fixed): one clock, `clock`. Reset `reset_n` is asynchronous and active-low.

Behaviour:
- Internal state:
  - EX slot: ex_rs_q, ex_rt_q, ex_use_rs_q, ex_use_rt_q, ex_valid_q.
  - MEM slot: mem_dest_q, mem_wr_q.
  - WB slot: wb_dest_q, wb_wr_q.
  - stall_count.
- Reset (async assert, sync-safe deassert):
  - All state clears to 0. ex_valid_q=0, so the EX slot is empty.
  - Outputs after reset: stall=0, fwd_a=fwd_b=00, id_byp_*=0, stall_count=0.
- ex_wr_eff = ex_reg_write & ex_valid_q. Bubbles never count as writers, even if the external control has not yet zeroed ex_reg_write.
- stall (combinational) = ex_mem_read & ex_wr_eff & (ex_dest!=0) & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
- Every rising edge, EX→MEM→WB always advances:
  - mem_dest_q<=ex_dest; mem_wr_q<=ex_wr_eff.
  - wb_dest_q<=mem_dest_q; wb_wr_q<=mem_wr_q.
- ID→EX on the same edge:
  - stall=0: ex_rs_q<=id_rs; ex_rt_q<=id_rt; ex_use_*_q<=id_use_*; ex_valid_q<=1.
  - stall=1: bubble. ex_valid_q<=0 and ex_use_*_q<=0; the rs/rt numbers are don't-care.
- Load-use stall length is exactly 1 cycle. Next cycle the load sits in MEM, so forwarding covers everything except the load result itself.
  - The load result is handled by MEM-load data from the WB path: the stalled consumer reaches EX when the load is in WB, so fwd=01.
- fwd_a (combinational from registered state only):
  - 10 if ex_use_rs_q & mem_wr_q & mem_dest_q!=0 & mem_dest_q==ex_rs_q;
  - else 01 if the same test holds against wb_*;
  - else 00.
  - MEM has priority over WB.
- fwd_b: identical, using ex_rt_q / ex_use_rt_q.
- id_byp_rs = id_use_rs & wb_wr_q & wb_dest_q!=0 & wb_dest_q==id_rs. id_byp_rt likewise.
- Register 0: never forwarded, never stalls, never bypassed.
- stall_count increments by 1 on each edge where stall=1. It saturates at all-ones and does not wrap.
- Reset mid-operation: all in-flight shadow state is discarded immediately (async). Outputs return to their reset values within the same cycle.
- Simultaneous MEM and WB match on the same register: MEM wins. This is the youngest value.

Decomposition:
- Shared package (mips_pkg):
  - REG_W and the register-number type.
  - FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - REG_ZERO=5'd0.
- One natural sub-module: src_match (one source number + use flag against one dest + write flag, with the zero check). It is instantiated for the ID-vs-EX, EX-vs-MEM, EX-vs-WB and ID-vs-WB comparisons.

Test Plan:
- Reset: hold reset_n=0 with nonzero inputs. Require all outputs 0 and stall_count=0. Release and check that the first non-stalled cycle loads the EX slot.
- ALU back-to-back: EX writes $8 (ex_reg_write=1, ex_mem_read=0), ID reads rs=$8. Require stall=0. Next cycle fwd_a=10. Following instruction also reading $8 gets fwd_a=01.
- Load-use: EX is a load to $9, ID reads rt=$9. Require stall=1 for exactly 1 cycle and stall_count 0→1. Consumer then in EX shows fwd_b=01, and no second stall.
- Priority: MEM writes $5 and WB writes $5, EX reads rs=$5. Require fwd_a=10.
- Zero register: load to $0 with ID reading $0. Require stall=0, fwd=00, id_byp=0.
- Saturation and async reset: force 2^16+3 stall cycles and require stall_count=16'hFFFF. Assert reset_n mid-stream with mem_wr_q=1. Require fwd/stall to clear without waiting for a clock edge.
